mem_req_tid_arbiter: RTL and testbench
======================================

# mem_req_tid_arbiter

Round-robin arbiter that shares the single memory request port of the cv32a6 cache subsystem between its requesters: I-cache refill, D-cache miss, and the write-through write buffer. It assigns each accepted request a transaction ID from a pool of 2^TidWidth IDs. It tracks which requester owns each in-flight ID and routes memory responses back to that requester. It sits between the caches and the memory-side bus adapter.

## Interface
- NumReq, 3: number of requesters; index 0 = I-cache, 1 = D-cache miss, 2 = write buffer
- TidWidth, 2: transaction ID width; pool holds 2^TidWidth IDs
- AddrWidth, 32: request address width
- DataWidth, 64: write/read data width

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester accept; one-hot or zero
- req_we_i  in  NumReq  1 = write, 0 = read
- req_addr_i  in  NumReq*AddrWidth  per-requester address, packed, requester 0 in LSBs
- req_wdata_i  in  NumReq*DataWidth  per-requester write data, packed
- mem_req_valid_o  out  1  output request valid
- mem_req_ready_i  in  1  memory accepts output request
- mem_req_we_o  out  1  write flag of output request
- mem_req_addr_o  out  AddrWidth  address of output request
- mem_req_wdata_o  out  DataWidth  write data of output request
- mem_req_tid_o  out  TidWidth  ID assigned to output request
- mem_rsp_valid_i  in  1  response valid; always consumed, no backpressure
- mem_rsp_tid_i  in  TidWidth  response ID
- mem_rsp_rdata_i  in  DataWidth  read data; don't-care for write acks
- rsp_valid_o  out  NumReq  one-cycle pulse to the owning requester
- rsp_rdata_o  out  DataWidth  registered copy of mem_rsp_rdata_i
- tid_err_o  out  1  one-cycle pulse: response with an ID that is not in flight
- busy_o  out  1  at least one ID in flight or output stage full

## Operation
- State:
  - output register stage (valid, we, addr, wdata, tid)
  - busy bit and owner index per ID
  - round-robin pointer `rr_q`, range 0..NumReq-1
- Stage free this cycle = `!mem_req_valid_o || mem_req_ready_i`.
- Grant conditions, all required in the same cycle:
  - stage free
  - at least one ID not busy, using the registered busy vector
  - at least one req_valid_i set
- Winner: first requester with valid set, scanning from `rr_q` upward and wrapping modulo NumReq.
- On grant:
  - `req_ready_o[winner]` = 1.
  - Stage loads the winner's we/addr/wdata and the lowest-index free ID.
  - That ID is marked busy with owner = winner.
  - `rr_q` becomes (winner + 1) mod NumReq.
- No grant: `rr_q` holds. If the stage is not free, its contents stay stable until mem_req_ready_i.
- Response with a busy ID:
  - Clear that ID's busy bit.
  - Register `rsp_valid_o[owner]` = 1 and `rsp_rdata_o` = mem_rsp_rdata_i.
- Response with a non-busy ID: busy state unchanged, rsp_valid_o stays 0, tid_err_o pulses.
- Simultaneous free and allocate in one cycle: the freed ID is not allocatable until the next cycle. The allocator reads only registered state.
- All IDs busy: req_ready_o = 0. Requesters hold valid; requests are not dropped.
- No ordering guarantee across IDs. Responses are routed only by ID.
- Reset mid-operation: all in-flight IDs are forgotten. Responses arriving after reset release are flagged by tid_err_o.

## Timing
- Reset values: mem_req_valid_o = 0, all mem_req_* data = 0, req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, tid_err_o = 0, busy_o = 0, `rr_q` = 0, all IDs free.
- req_ready_o is combinational from req_valid_i, mem_req_ready_i and registered state.
- Request path: accept in cycle N gives mem_req_valid_o = 1 in cycle N+1.
- Throughput: one request per cycle while mem_req_ready_i stays high and IDs are available.
- Response path: mem_rsp_valid_i in cycle N gives rsp_valid_o / tid_err_o in cycle N+1 for exactly one cycle.
- busy_o is registered and reflects the state after the current edge.

## Test plan
- Reset, then requester 1 issues a read to 0x8000_0040 with mem_req_ready_i = 1 -> req_ready_o = 3'b010 that cycle; next cycle mem_req_valid_o = 1, addr 0x8000_0040, tid 0, we 0. Response tid 0, rdata 0xDEAD_BEEF_0000_0001 -> next cycle rsp_valid_o = 3'b010 and rsp_rdata_o equal to that value.
- All three requesters hold valid, ready = 1, responses returned immediately -> grants go 0, 1, 2, 0, 1, 2 in consecutive cycles.
- No responses, 5 back-to-back requests -> IDs 0, 1, 2, 3 issued, then req_ready_o = 0 and busy_o = 1. Respond tid 2 -> the next grant uses tid 2 one cycle after the response, not the same cycle.
- mem_req_ready_i = 0 for 3 cycles with the stage full -> mem_req_* outputs constant and req_ready_o = 0 throughout; ready high -> a new grant occurs in that same cycle.
- Response with tid 3 while only tid 0 is in flight -> tid_err_o pulses once, rsp_valid_o = 0, tid 0 stays busy.
- Assert rst_i with 2 IDs in flight -> all outputs go to reset values immediately. After release, a request gets tid 0 and `rr_q` restarts at requester 0.

Source files
------------

// File: rtl/mem_req_tid_arbiter_if.sv
// mem_req_tid_arbiter_if
// Bundles the requester-side, memory-request-side and memory-response-side
// signals of mem_req_tid_arbiter.
//   slave  : the arbiter (drives req_ready_o, mem_req_*_o, rsp_*_o, tid_err_o, busy_o)
//   master : the environment (caches, write buffer, memory-side adapter)
interface mem_req_tid_arbiter_if #(
  parameter int NumReq    = 3,
  parameter int TidWidth  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
);
  // requester side
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq-1:0]           req_we_i;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq*DataWidth-1:0] req_wdata_i;
  // memory request side
  logic                        mem_req_valid_o;
  logic                        mem_req_ready_i;
  logic                        mem_req_we_o;
  logic [AddrWidth-1:0]        mem_req_addr_o;
  logic [DataWidth-1:0]        mem_req_wdata_o;
  logic [TidWidth-1:0]         mem_req_tid_o;
  // memory response side
  logic                        mem_rsp_valid_i;
  logic [TidWidth-1:0]         mem_rsp_tid_i;
  logic [DataWidth-1:0]        mem_rsp_rdata_i;
  // response routing and status
  logic [NumReq-1:0]           rsp_valid_o;
  logic [DataWidth-1:0]        rsp_rdata_o;
  logic                        tid_err_o;
  logic                        busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    output req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
    output mem_req_wdata_o, mem_req_tid_o, rsp_valid_o, rsp_rdata_o,
    output tid_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    input  req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
    input  mem_req_wdata_o, mem_req_tid_o, rsp_valid_o, rsp_rdata_o,
    input  tid_err_o, busy_o
  );
endinterface

// File: rtl/mem_req_tid_arbiter.sv
// mem_req_tid_arbiter
// Round-robin arbiter sharing one memory request port between the I-cache
// (0), the D-cache miss path (1) and the write buffer (2). Every accepted
// request gets the lowest free transaction ID; the owner of each in-flight
// ID is remembered so responses are routed back by ID alone.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : mem_req_tid_arbiter_if.slave (requests, memory request,
//            memory response, routed response, tid_err_o, busy_o)
module mem_req_tid_arbiter #(
  parameter int NumReq    = 3,
  parameter int TidWidth  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mem_req_tid_arbiter_if.slave  bus
);

  localparam int NumTid  = 1 << TidWidth;
  localparam int RrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  function automatic logic [NumReq-1:0] req_onehot(input logic [RrWidth-1:0] idx);
    req_onehot = NumReq'(1'b1) << idx;
  endfunction

  // output stage
  logic                         mem_valid_q, mem_valid_d;
  logic                         mem_we_q, mem_we_d;
  logic [AddrWidth-1:0]         mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0]         mem_wdata_q, mem_wdata_d;
  logic [TidWidth-1:0]          mem_tid_q, mem_tid_d;
  // ID pool
  logic [NumTid-1:0]            tid_busy_q, tid_busy_d;
  logic [NumTid-1:0][RrWidth-1:0] tid_owner_q, tid_owner_d;
  // arbitration and response side
  logic [RrWidth-1:0]           rr_q, rr_d;
  logic [NumReq-1:0]            rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic                         tid_err_q, tid_err_d;
  logic                         busy_q, busy_d;

  logic                         stage_free_s;
  logic                         free_any_s;
  logic [TidWidth-1:0]          free_tid_s;
  logic                         winner_found_s;
  logic [RrWidth-1:0]           winner_s;
  logic                         grant_s;
  logic                         rsp_hit_s;

  assign stage_free_s = !mem_valid_q || bus.mem_req_ready_i;

  // Lowest-index free ID; only the registered busy vector is consulted, so an
  // ID freed this cycle becomes allocatable on the next one.
  always_comb begin
    free_tid_s = '0;
    free_any_s = 1'b0;
    for (int t = NumTid - 1; t >= 0; t--) begin
      free_tid_s = tid_busy_q[t] ? free_tid_s : TidWidth'(t);
      free_any_s = free_any_s | !tid_busy_q[t];
    end
  end

  // Round-robin winner: first valid requester scanning upward from rr_q.
  always_comb begin : winner_scan
    logic [RrWidth-1:0] cand;
    logic               take;
    winner_s       = rr_q;
    winner_found_s = 1'b0;
    cand           = '0;
    take           = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      cand           = RrWidth'((int'(rr_q) + k) % NumReq);
      take           = bus.req_valid_i[cand] && !winner_found_s;
      winner_s       = take ? cand : winner_s;
      winner_found_s = winner_found_s | take;
    end
  end

  // Reset also blocks grants so req_ready_o reads zero while rst_i is held.
  assign grant_s     = !rst_i && stage_free_s && free_any_s && winner_found_s;
  assign rsp_hit_s   = bus.mem_rsp_valid_i && tid_busy_q[bus.mem_rsp_tid_i];
  assign bus.req_ready_o = grant_s ? req_onehot(winner_s) : '0;

  // Next-state for the output stage.
  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_tid_d   = mem_tid_q;
    if (grant_s) begin
      mem_valid_d = 1'b1;
      mem_we_d    = bus.req_we_i[winner_s];
      mem_addr_d  = bus.req_addr_i[winner_s*AddrWidth +: AddrWidth];
      mem_wdata_d = bus.req_wdata_i[winner_s*DataWidth +: DataWidth];
      mem_tid_d   = free_tid_s;
    end else if (bus.mem_req_ready_i) begin
      mem_valid_d = 1'b0;
    end else begin
      mem_valid_d = mem_valid_q;
    end
  end

  // Next-state for the ID pool, round-robin pointer and response outputs.
  always_comb begin
    tid_busy_d  = tid_busy_q;
    tid_owner_d = tid_owner_q;
    rr_d        = rr_q;
    // a hit ID is busy, an allocated ID is free: the two never collide
    if (rsp_hit_s) begin
      tid_busy_d[bus.mem_rsp_tid_i] = 1'b0;
    end else begin
      tid_busy_d = tid_busy_d;
    end
    if (grant_s) begin
      tid_busy_d[free_tid_s]  = 1'b1;
      tid_owner_d[free_tid_s] = winner_s;
      rr_d = (winner_s == RrWidth'(NumReq - 1)) ? '0 : winner_s + RrWidth'(1);
    end else begin
      rr_d = rr_q;
    end
    rsp_valid_d = rsp_hit_s ? req_onehot(tid_owner_q[bus.mem_rsp_tid_i]) : '0;
    rsp_rdata_d = rsp_hit_s ? bus.mem_rsp_rdata_i : rsp_rdata_q;
    tid_err_d   = bus.mem_rsp_valid_i && !tid_busy_q[bus.mem_rsp_tid_i];
    busy_d      = mem_valid_d || (|tid_busy_d);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_tid_q   <= '0;
      tid_busy_q  <= '0;
      tid_owner_q <= '0;
      rr_q        <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      tid_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_tid_q   <= mem_tid_d;
      tid_busy_q  <= tid_busy_d;
      tid_owner_q <= tid_owner_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      tid_err_q   <= tid_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req_valid_o = mem_valid_q;
  assign bus.mem_req_we_o    = mem_we_q;
  assign bus.mem_req_addr_o  = mem_addr_q;
  assign bus.mem_req_wdata_o = mem_wdata_q;
  assign bus.mem_req_tid_o   = mem_tid_q;
  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.rsp_rdata_o     = rsp_rdata_q;
  assign bus.tid_err_o       = tid_err_q;
  assign bus.busy_o          = busy_q;

endmodule

// File: tb/tb_mem_req_tid_arbiter.sv
module tb_mem_req_tid_arbiter;
  localparam int NR = 3;
  localparam int TW = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int NT = 4;

  logic clk = 1'b0;
  logic rst;

  mem_req_tid_arbiter_if #(.NumReq(NR), .TidWidth(TW), .AddrWidth(AW), .DataWidth(DW)) bus ();

  mem_req_tid_arbiter #(.NumReq(NR), .TidWidth(TW), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model: set of in-flight IDs with owners, next-in-turn requester
  int  m_rr;
  bit  m_busy [NT];
  int  m_owner[NT];
  bit  m_stage;
  bit  exp_busy;
  bit  ready_at_edge;

  typedef struct {
    int            due;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [TW-1:0] tid;
  } req_t;
  typedef struct {
    int            due;
    logic [NR-1:0] vec;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   dut_gnt_log[$];

  logic [AW-1:0] addr_v [NR];
  logic [DW-1:0] wdata_v[NR];
  logic [NR-1:0] we_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic void model_reset();
    m_rr = 0;
    m_stage = 1'b0;
    exp_busy = 1'b0;
    for (int t = 0; t < NT; t++) begin
      m_busy[t] = 1'b0;
      m_owner[t] = 0;
    end
  endfunction

  // Reference model: evaluated mid-cycle once inputs are stable.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
      end else begin
        int w;
        int ft;
        int rt;
        logic [NR-1:0] exp_ready;
        w  = -1;
        ft = -1;
        for (int t = 0; t < NT; t++)
          if (!m_busy[t] && ft < 0) ft = t;
        if ((!m_stage || bus.mem_req_ready_i) && ft >= 0)
          for (int k = 0; k < NR; k++)
            if (w < 0 && bus.req_valid_i[(m_rr + k) % NR]) w = (m_rr + k) % NR;
        exp_ready = (w >= 0) ? NR'(1 << w) : '0;
        chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
        for (int i = 0; i < NR; i++)
          if (bus.req_ready_o[i]) dut_gnt_log.push_back(i);
        ready_at_edge = bus.mem_req_ready_i;
        if (bus.mem_rsp_valid_i) begin
          rt = int'(bus.mem_rsp_tid_i);
          if (m_busy[rt]) begin
            exp_rsp_q.push_back('{cyc_n + 1, NR'(1 << m_owner[rt]), bus.mem_rsp_rdata_i, 1'b0});
            m_busy[rt] = 1'b0;
          end else begin
            exp_rsp_q.push_back('{cyc_n + 1, '0, '0, 1'b1});
          end
        end
        if (w >= 0) begin
          exp_req_q.push_back('{cyc_n + 1, bus.req_we_i[w],
                                bus.req_addr_i[w*AW +: AW], bus.req_wdata_i[w*DW +: DW], TW'(ft)});
          m_busy[ft]  = 1'b1;
          m_owner[ft] = w;
          m_rr        = (w + 1) % NR;
          m_stage     = 1'b1;
        end else if (bus.mem_req_ready_i) begin
          m_stage = 1'b0;
        end
        exp_busy = m_stage;
        for (int t = 0; t < NT; t++) exp_busy = exp_busy | m_busy[t];
      end
    end
  end

  // Monitor: compares registered outputs against the scoreboard after each edge.
  initial begin
    logic          pv;
    logic          pwe;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [TW-1:0] pt;
    req_t          er;
    rsp_t          es;
    pv = 1'b0; pwe = 1'b0; pa = '0; pd = '0; pt = '0;
    forever begin
      @(posedge clk);
      cyc_n++;
      #3;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !ready_at_edge) begin
          chk("hold_valid", 64'(bus.mem_req_valid_o), 64'd1);
          chk("hold_we",    64'(bus.mem_req_we_o), 64'(pwe));
          chk("hold_addr",  64'(bus.mem_req_addr_o), 64'(pa));
          chk("hold_wdata", bus.mem_req_wdata_o, pd);
          chk("hold_tid",   64'(bus.mem_req_tid_o), 64'(pt));
        end else if (exp_req_q.size() > 0 && exp_req_q[0].due == cyc_n) begin
          er = exp_req_q.pop_front();
          chk("req_valid", 64'(bus.mem_req_valid_o), 64'd1);
          chk("req_we",    64'(bus.mem_req_we_o), 64'(er.we));
          chk("req_addr",  64'(bus.mem_req_addr_o), 64'(er.addr));
          chk("req_wdata", bus.mem_req_wdata_o, er.wdata);
          chk("req_tid",   64'(bus.mem_req_tid_o), 64'(er.tid));
        end else begin
          chk("req_idle", 64'(bus.mem_req_valid_o), 64'd0);
        end
        if (exp_rsp_q.size() > 0 && exp_rsp_q[0].due == cyc_n) begin
          es = exp_rsp_q.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(es.vec));
          chk("tid_err",   64'(bus.tid_err_o), 64'(es.err));
          if (es.vec != '0) chk("rsp_rdata", bus.rsp_rdata_o, es.rdata);
        end else begin
          chk("rsp_idle", 64'(bus.rsp_valid_o), 64'd0);
          chk("err_idle", 64'(bus.tid_err_o), 64'd0);
        end
        chk("busy", 64'(bus.busy_o), 64'(exp_busy));
        pv  = bus.mem_req_valid_o;
        pwe = bus.mem_req_we_o;
        pa  = bus.mem_req_addr_o;
        pd  = bus.mem_req_wdata_o;
        pt  = bus.mem_req_tid_o;
      end
    end
  end

  task automatic rand_payload();
    for (int i = 0; i < NR; i++) begin
      addr_v[i]  = $urandom;
      wdata_v[i] = {$urandom, $urandom};
      we_v[i]    = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock: drive inputs just after an edge, return just after the next edge.
  task automatic cyc(input logic [NR-1:0] v, input logic mrdy, input logic rv,
                     input logic [TW-1:0] rt, input logic [DW-1:0] rd);
    bus.req_valid_i = v;
    bus.req_we_i    = we_v;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr_i[i*AW +: AW]  = addr_v[i];
      bus.req_wdata_i[i*DW +: DW] = wdata_v[i];
    end
    bus.mem_req_ready_i = mrdy;
    bus.mem_rsp_valid_i = rv;
    bus.mem_rsp_tid_i   = rt;
    bus.mem_rsp_rdata_i = rd;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_mem_valid", 64'(bus.mem_req_valid_o), 64'd0);
    chk("rst_mem_we",    64'(bus.mem_req_we_o), 64'd0);
    chk("rst_mem_addr",  64'(bus.mem_req_addr_o), 64'd0);
    chk("rst_mem_wdata", bus.mem_req_wdata_o, 64'd0);
    chk("rst_mem_tid",   64'(bus.mem_req_tid_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 64'd0);
    chk("rst_tid_err",   64'(bus.tid_err_o), 64'd0);
    chk("rst_busy",      64'(bus.busy_o), 64'd0);
    exp_req_q.delete();
    exp_rsp_q.delete();
    dut_gnt_log.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    we_v = '0;
    for (int i = 0; i < NR; i++) begin
      addr_v[i] = '0;
      wdata_v[i] = '0;
    end
    bus.req_valid_i = '0;
    bus.req_we_i = '0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_tid_i = '0;
    bus.mem_rsp_rdata_i = '0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // single read from requester 1, then its response
    do_reset();
    rand_payload();
    addr_v[1] = 32'h8000_0040;
    we_v[1]   = 1'b0;
    cyc(3'b010, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("t1_valid", 64'(bus.mem_req_valid_o), 64'd1);
    chk("t1_addr",  64'(bus.mem_req_addr_o), 64'h8000_0040);
    chk("t1_tid",   64'(bus.mem_req_tid_o), 64'd0);
    chk("t1_we",    64'(bus.mem_req_we_o), 64'd0);
    cyc(3'b000, 1'b1, 1'b1, 2'd0, 64'hDEAD_BEEF_0000_0001);
    chk("t1_rsp_valid", 64'(bus.rsp_valid_o), 64'd2);
    chk("t1_rsp_rdata", bus.rsp_rdata_o, 64'hDEAD_BEEF_0000_0001);

    // round robin with all three requesting and immediate responses
    do_reset();
    for (int n = 0; n < 6; n++) begin
      rand_payload();
      cyc(3'b111, 1'b1, bus.mem_req_valid_o, bus.mem_req_tid_o, {$urandom, $urandom});
    end
    chk("rr_count", 64'(dut_gnt_log.size()), 64'd6);
    for (int n = 0; n < 6 && n < dut_gnt_log.size(); n++)
      chk("rr_order", 64'(dut_gnt_log[n]), 64'(n % 3));

    // exhaust the ID pool, then free tid 2
    do_reset();
    for (int n = 0; n < 5; n++) begin
      rand_payload();
      cyc(3'b001, 1'b1, 1'b0, 2'd0, 64'd0);
    end
    chk("full_ready", 64'(bus.req_ready_o), 64'd0);
    chk("full_busy",  64'(bus.busy_o), 64'd1);
    cyc(3'b001, 1'b1, 1'b1, 2'd2, 64'h1234);
    cyc(3'b001, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("reuse_valid", 64'(bus.mem_req_valid_o), 64'd1);
    chk("reuse_tid",   64'(bus.mem_req_tid_o), 64'd2);

    // output stage stalled for three cycles
    do_reset();
    rand_payload();
    cyc(3'b001, 1'b1, 1'b0, 2'd0, 64'd0);
    for (int n = 0; n < 3; n++) begin
      rand_payload();
      cyc(3'b011, 1'b0, 1'b0, 2'd0, 64'd0);
      chk("stall_ready", 64'(bus.req_ready_o), 64'd0);
    end
    cyc(3'b011, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("stall_release_tid", 64'(bus.mem_req_tid_o), 64'd1);
    chk("stall_release_gnt", 64'(dut_gnt_log[dut_gnt_log.size() - 1]), 64'd1);

    // response for an ID that is not in flight
    do_reset();
    cyc(3'b001, 1'b1, 1'b0, 2'd0, 64'd0);
    cyc(3'b000, 1'b1, 1'b1, 2'd3, 64'hFFFF);
    chk("err_pulse", 64'(bus.tid_err_o), 64'd1);
    chk("err_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    cyc(3'b000, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("err_once", 64'(bus.tid_err_o), 64'd0);
    chk("err_busy_kept", 64'(bus.busy_o), 64'd1);

    // reset with two IDs in flight
    do_reset();
    cyc(3'b001, 1'b1, 1'b0, 2'd0, 64'd0);
    cyc(3'b010, 1'b1, 1'b0, 2'd0, 64'd0);
    do_reset();
    rand_payload();
    cyc(3'b111, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("post_rst_tid", 64'(bus.mem_req_tid_o), 64'd0);
    chk("post_rst_gnt", 64'(dut_gnt_log[dut_gnt_log.size() - 1]), 64'd0);
    cyc(3'b000, 1'b1, 1'b1, 2'd1, 64'd5);
    chk("post_rst_stale_err", 64'(bus.tid_err_o), 64'd1);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_payload();
      cyc(NR'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 4), TW'($urandom_range(0, 3)), {$urandom, $urandom});
    end
    for (int n = 0; n < 3; n++) cyc(3'b000, 1'b1, 1'b0, 2'd0, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
